disk_controller_sd_cmd: RTL and testbench

//  Sequences the SPI byte engine (strobe/busy, one byte per transfer) to run one SD-card SPI-mode

---
 rtl/disk_controller_pkg.sv | 23 ++
 rtl/disk_controller_crc7.sv | 27 ++
 rtl/disk_controller_sd_cmd.sv | 183 ++++++++++++++++++
 tb/tb_disk_controller_sd_cmd.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disk_controller_pkg.sv
// rtl/disk_controller_pkg.sv - shared encodings and constants for the SD SPI command sequencer
package disk_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_FRAME,
        ST_POLL,
        ST_EXT,
        ST_TRAIL,
        ST_DONE
    } sd_state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } sd_phase_t;

    localparam logic [1:0] SD_CMD_START = 2'b01;
    localparam logic [7:0] SD_FILL      = 8'hFF;
    localparam logic [6:0] CRC7_POLY    = 7'h09;

endpackage

// File: rtl/disk_controller_crc7.sv
// rtl/disk_controller_crc7.sv - byte-wise CRC7 (x^7+x^3+1) update, MSB first
module disk_controller_crc7
    import disk_controller_pkg::*;
(
    input  logic [6:0] crc7_i,
    input  logic [7:0] byte_i,
    output logic [6:0] crc7_o
);

    logic [6:0] crc;
    logic       fb;

    // Shift the eight message bits through the LFSR, most significant bit first
    always_comb begin
        crc = crc7_i;
        fb  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb  = crc[6] ^ byte_i[3'(7 - i)];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC7_POLY;
            end
        end
        crc7_o = crc;
    end

endmodule

// File: rtl/disk_controller_sd_cmd.sv
// rtl/disk_controller_sd_cmd.sv - runs one SD SPI-mode command over the byte engine
module disk_controller_sd_cmd
    import disk_controller_pkg::*;
#(
    parameter int POLL_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_start_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    input  logic        cmd_long_i,
    input  logic        cmd_keep_cs_i,
    output logic        cmd_busy_o,
    output logic        cmd_done_o,
    output logic [7:0]  cmd_r1_o,
    output logic [31:0] cmd_ext_o,
    output logic        cmd_timeout_o,
    output logic        cs_n_o,
    output logic [7:0]  spi_dat_o,
    input  logic [7:0]  spi_dat_i,
    output logic        spi_strobe_o,
    input  logic        spi_busy_i
);

    sd_state_t  state;
    sd_phase_t  phase;
    logic [2:0] byte_cnt;
    logic [7:0] poll_cnt;
    logic [7:0] poll_next;
    logic [5:0] index_q;
    logic [31:0] arg_q;
    logic       long_q;
    logic       keep_q;
    logic [6:0] crc_q;
    logic [6:0] crc_next;
    logic [7:0] frame_byte;
    logic [7:0] tx_byte;

    assign poll_next = poll_cnt + 8'd1;

    // Select the frame byte for the current position; the last byte carries the finished CRC
    always_comb begin
        frame_byte = {crc_q, 1'b1};
        case (byte_cnt)
            3'd0:    frame_byte = {SD_CMD_START, index_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            default: frame_byte = {crc_q, 1'b1};
        endcase
        tx_byte = (state == ST_FRAME) ? frame_byte : SD_FILL;
    end

    disk_controller_crc7 u_crc7 (
        .crc7_i (crc_q),
        .byte_i (frame_byte),
        .crc7_o (crc_next)
    );

    // Command sequencer: each byte is ISSUE (raise strobe) then WAIT (drop strobe, wait for engine idle)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            phase         <= PH_ISSUE;
            byte_cnt      <= 3'd0;
            poll_cnt      <= 8'd0;
            index_q       <= 6'd0;
            arg_q         <= 32'd0;
            long_q        <= 1'b0;
            keep_q        <= 1'b0;
            crc_q         <= 7'd0;
            cmd_busy_o    <= 1'b0;
            cmd_done_o    <= 1'b0;
            cmd_r1_o      <= 8'hFF;
            cmd_ext_o     <= 32'd0;
            cmd_timeout_o <= 1'b0;
            cs_n_o        <= 1'b1;
            spi_dat_o     <= 8'd0;
            spi_strobe_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_start_i) begin
                        index_q       <= cmd_index_i;
                        arg_q         <= cmd_arg_i;
                        long_q        <= cmd_long_i;
                        keep_q        <= cmd_keep_cs_i;
                        cmd_r1_o      <= 8'hFF;
                        cmd_ext_o     <= 32'd0;
                        cmd_timeout_o <= 1'b0;
                        crc_q         <= 7'd0;
                        byte_cnt      <= 3'd0;
                        poll_cnt      <= 8'd0;
                        cmd_busy_o    <= 1'b1;
                        cs_n_o        <= 1'b0;
                        phase         <= PH_ISSUE;
                        state         <= ST_LEAD;
                    end
                end

                ST_DONE: begin
                    cmd_done_o <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    if (phase == PH_ISSUE) begin
                        spi_strobe_o <= 1'b1;
                        spi_dat_o    <= tx_byte;
                        phase        <= PH_WAIT;
                        if (state == ST_FRAME && byte_cnt < 3'd5) begin
                            crc_q <= crc_next;
                        end
                    end else if (spi_strobe_o) begin
                        spi_strobe_o <= 1'b0;
                    end else if (!spi_busy_i) begin
                        phase <= PH_ISSUE;
                        case (state)
                            ST_LEAD: begin
                                byte_cnt <= 3'd0;
                                state    <= ST_FRAME;
                            end
                            ST_FRAME: begin
                                if (byte_cnt == 3'd5) begin
                                    poll_cnt <= 8'd0;
                                    state    <= ST_POLL;
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                end
                            end
                            ST_POLL: begin
                                if (!spi_dat_i[7]) begin
                                    cmd_r1_o <= spi_dat_i;
                                    if (long_q) begin
                                        byte_cnt <= 3'd0;
                                        state    <= ST_EXT;
                                    end else if (keep_q) begin
                                        cmd_done_o <= 1'b1;
                                        cmd_busy_o <= 1'b0;
                                        state      <= ST_DONE;
                                    end else begin
                                        cs_n_o <= 1'b1;
                                        state  <= ST_TRAIL;
                                    end
                                end else if (poll_next == 8'(POLL_LIMIT)) begin
                                    cmd_timeout_o <= 1'b1;
                                    cmd_r1_o      <= 8'hFF;
                                    cs_n_o        <= 1'b1;
                                    state         <= ST_TRAIL;
                                end else begin
                                    poll_cnt <= poll_next;
                                end
                            end
                            ST_EXT: begin
                                cmd_ext_o <= {cmd_ext_o[23:0], spi_dat_i};
                                if (byte_cnt == 3'd3) begin
                                    if (keep_q) begin
                                        cmd_done_o <= 1'b1;
                                        cmd_busy_o <= 1'b0;
                                        state      <= ST_DONE;
                                    end else begin
                                        cs_n_o <= 1'b1;
                                        state  <= ST_TRAIL;
                                    end
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                end
                            end
                            default: begin
                                cmd_done_o <= 1'b1;
                                cmd_busy_o <= 1'b0;
                                state      <= ST_DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disk_controller_sd_cmd.sv
// tb/tb_disk_controller_sd_cmd.sv - bench with byte engine and SD card model for disk_controller_sd_cmd
module tb_disk_controller_sd_cmd;

    localparam int POLL_LIMIT = 8;
    localparam int NEVER      = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        cmd_long = 1'b0;
    logic        cmd_keep_cs = 1'b0;
    logic        cmd_busy;
    logic        cmd_done;
    logic [7:0]  cmd_r1;
    logic [31:0] cmd_ext;
    logic        cmd_timeout;
    logic        cs_n;
    logic [7:0]  spi_dat_o;
    logic [7:0]  spi_dat_i = 8'hFF;
    logic        spi_strobe;
    logic        spi_busy = 1'b0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // engine and card model state
    int         eng_rem = 0;
    logic [7:0] pending = 8'hFF;
    logic       prev_strobe = 1'b0;
    logic [7:0] mosi_q[$];
    int         sess = 0;
    int         trail_cnt = 0;
    int         viol = 0;
    int         done_cnt = 0;
    int         c_delay = NEVER;
    logic [7:0] c_r1 = 8'h00;
    logic [31:0] c_ext = 32'd0;

    always #5 clk = ~clk;

    disk_controller_sd_cmd #(.POLL_LIMIT(POLL_LIMIT)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_start_i   (cmd_start),
        .cmd_index_i   (cmd_index),
        .cmd_arg_i     (cmd_arg),
        .cmd_long_i    (cmd_long),
        .cmd_keep_cs_i (cmd_keep_cs),
        .cmd_busy_o    (cmd_busy),
        .cmd_done_o    (cmd_done),
        .cmd_r1_o      (cmd_r1),
        .cmd_ext_o     (cmd_ext),
        .cmd_timeout_o (cmd_timeout),
        .cs_n_o        (cs_n),
        .spi_dat_o     (spi_dat_o),
        .spi_dat_i     (spi_dat_i),
        .spi_strobe_o  (spi_strobe),
        .spi_busy_i    (spi_busy)
    );

    // Byte engine plus SD card: busy for 1..4 cycles after each strobe, reply chosen by card script
    always @(negedge clk) begin
        int k;
        logic [31:0] t;
        if (rst) begin
            spi_busy    = 1'b0;
            eng_rem     = 0;
            prev_strobe = 1'b0;
        end else begin
            if (spi_strobe && (spi_busy || prev_strobe)) viol++;
            prev_strobe = spi_strobe;
            if (spi_busy) begin
                eng_rem--;
                if (eng_rem <= 0) begin
                    spi_busy  = 1'b0;
                    spi_dat_i = pending;
                end
            end
            if (spi_strobe && !spi_busy) begin
                spi_busy = 1'b1;
                eng_rem  = $urandom_range(1, 4);
                pending  = 8'hFF;
                if (cs_n) begin
                    trail_cnt++;
                end else begin
                    mosi_q.push_back(spi_dat_o);
                    k = sess - 7;
                    if (k >= 0 && k == c_delay) begin
                        pending = c_r1;
                    end else if (k > c_delay && k <= c_delay + 4) begin
                        t = c_ext << (8 * (k - c_delay - 1));
                        pending = t[31:24];
                    end
                    sess++;
                end
            end
            if (cmd_done) done_cnt++;
        end
    end

    function automatic logic [6:0] crc7_of(input logic [39:0] m);
        logic [6:0] c = 7'd0;
        logic fb;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ m[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n got %0b want 1", cs_n); else pass_cnt++;
        chk_cnt++; if (cmd_r1 !== 8'hFF) $display("FAIL reset_r1 got %02h want ff", cmd_r1); else pass_cnt++;
        chk_cnt++; if (cmd_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", cmd_busy); else pass_cnt++;
        chk_cnt++; if (cmd_done !== 1'b0) $display("FAIL reset_done got %0b want 0", cmd_done); else pass_cnt++;
        chk_cnt++; if (cmd_ext !== 32'd0) $display("FAIL reset_ext got %08h want 0", cmd_ext); else pass_cnt++;
        chk_cnt++; if (cmd_timeout !== 1'b0) $display("FAIL reset_timeout got %0b want 0", cmd_timeout); else pass_cnt++;
        chk_cnt++; if (spi_strobe !== 1'b0) $display("FAIL reset_strobe got %0b want 0", spi_strobe); else pass_cnt++;
        chk_cnt++; if (spi_dat_o !== 8'd0) $display("FAIL reset_spi_dat got %02h want 0", spi_dat_o); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one command against the card script and compares everything with the reference model
    task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input logic lng, input logic keep, input int delay,
                           input logic [7:0] r1, input logic [31:0] ext, input bit noise,
                           input int want_last);
        logic [7:0] exp_q[$];
        logic [6:0] crc;
        bit to_exp, seq_ok;
        int polls, cyc;
        logic [7:0] r1_exp;
        logic [31:0] ext_exp;
        logic cs_exp;
        mosi_q.delete();
        sess = 0; trail_cnt = 0; done_cnt = 0; viol = 0;
        c_delay = delay; c_r1 = r1; c_ext = ext;

        to_exp  = (delay >= POLL_LIMIT);
        polls   = to_exp ? POLL_LIMIT : delay + 1;
        crc     = crc7_of({2'b01, idx, arg});
        exp_q   = '{8'hFF, {2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc, 1'b1}};
        for (int i = 0; i < polls; i++) exp_q.push_back(8'hFF);
        if (lng && !to_exp) for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
        r1_exp  = to_exp ? 8'hFF : r1;
        ext_exp = (lng && !to_exp) ? ext : 32'd0;
        cs_exp  = (keep && !to_exp) ? 1'b0 : 1'b1;

        cmd_index = idx; cmd_arg = arg; cmd_long = lng; cmd_keep_cs = keep; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        if (noise) begin cmd_index = 6'h3F; cmd_arg = 32'hDEAD_BEEF; cmd_long = ~lng; cmd_keep_cs = ~keep; end
        chk_cnt++; if (cmd_busy !== 1'b1) $display("FAIL %s busy_after_start got %0b want 1", name, cmd_busy); else pass_cnt++;

        cyc = 0;
        while (!cmd_done && cyc < 3000) begin
            cmd_start = noise && (cyc % 5 == 2);
            @(negedge clk);
            cyc++;
        end
        cmd_start = noise;
        chk_cnt++;
        if (!cmd_done) begin
            $display("FAIL %s done_wait got no done within %0d cycles want done", name, cyc);
            cmd_start = 1'b0;
            return;
        end
        pass_cnt++;
        chk_cnt++; if (cmd_busy !== 1'b0) $display("FAIL %s busy_at_done got %0b want 0", name, cmd_busy); else pass_cnt++;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (20) @(negedge clk);

        seq_ok = (mosi_q.size() == exp_q.size());
        if (seq_ok) for (int i = 0; i < exp_q.size(); i++) if (mosi_q[i] !== exp_q[i]) seq_ok = 0;
        chk_cnt++; if (!seq_ok) $display("FAIL %s mosi_seq got %0d bytes %p want %0d bytes %p", name, mosi_q.size(), mosi_q, exp_q.size(), exp_q); else pass_cnt++;
        if (want_last >= 0) begin
            chk_cnt++;
            if (mosi_q.size() < 7 || mosi_q[6] !== 8'(want_last)) $display("FAIL %s crc_byte got %02h want %02h", name, (mosi_q.size() < 7) ? 8'h00 : mosi_q[6], 8'(want_last));
            else pass_cnt++;
        end
        chk_cnt++; if (cmd_r1 !== r1_exp) $display("FAIL %s r1 got %02h want %02h", name, cmd_r1, r1_exp); else pass_cnt++;
        chk_cnt++; if (cmd_ext !== ext_exp) $display("FAIL %s ext got %08h want %08h", name, cmd_ext, ext_exp); else pass_cnt++;
        chk_cnt++; if (cmd_timeout !== to_exp) $display("FAIL %s timeout got %0b want %0b", name, cmd_timeout, to_exp); else pass_cnt++;
        chk_cnt++; if (cs_n !== cs_exp) $display("FAIL %s cs_n_end got %0b want %0b", name, cs_n, cs_exp); else pass_cnt++;
        chk_cnt++; if (trail_cnt !== int'(cs_exp)) $display("FAIL %s trail_bytes got %0d want %0d", name, trail_cnt, int'(cs_exp)); else pass_cnt++;
        chk_cnt++; if (done_cnt !== 1) $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); else pass_cnt++;
        chk_cnt++; if (cmd_busy !== 1'b0) $display("FAIL %s busy_idle got %0b want 0", name, cmd_busy); else pass_cnt++;
        chk_cnt++; if (viol !== 0) $display("FAIL %s strobe_protocol got %0d violations want 0", name, viol); else pass_cnt++;
    endtask

    task automatic test_cmd0();
        run_cmd("cmd0", 6'd0, 32'd0, 1'b0, 1'b0, 1, 8'h01, 32'd0, 1'b0, 'h95);
    endtask

    task automatic test_cmd8_long();
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b1, 1'b0, 0, 8'h01, 32'h0000_01AA, 1'b0, 'h87);
    endtask

    task automatic test_timeout();
        run_cmd("timeout", 6'd55, 32'd0, 1'b0, 1'b1, NEVER, 8'h00, 32'd0, 1'b0, -1);
    endtask

    task automatic test_keep_cs();
        run_cmd("cmd17_keep", 6'd17, 32'h0000_0200, 1'b0, 1'b1, 2, 8'h00, 32'd0, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        run_cmd("ignore_start", 6'd58, 32'd0, 1'b1, 1'b0, 3, 8'h00, 32'hC0FF_8000, 1'b1, -1);
    endtask

    task automatic test_reset_mid_frame();
        int cyc, n;
        mosi_q.delete();
        sess = 0; trail_cnt = 0; done_cnt = 0; viol = 0; c_delay = 0; c_r1 = 8'h00;
        cmd_index = 6'd17; cmd_arg = 32'h1234_5678; cmd_long = 1'b0; cmd_keep_cs = 1'b0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cyc = 0;
        while (mosi_q.size() < 3 && cyc < 500) begin @(negedge clk); cyc++; end
        chk_cnt++; if (mosi_q.size() < 3) $display("FAIL rst_mid reach_frame got %0d bytes want 3", mosi_q.size()); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if (cs_n !== 1'b1) $display("FAIL rst_mid cs_n got %0b want 1", cs_n); else pass_cnt++;
        chk_cnt++; if (cmd_busy !== 1'b0) $display("FAIL rst_mid busy got %0b want 0", cmd_busy); else pass_cnt++;
        rst = 1'b0;
        n = mosi_q.size();
        repeat (50) @(negedge clk);
        chk_cnt++; if (done_cnt !== 0) $display("FAIL rst_mid done_pulses got %0d want 0", done_cnt); else pass_cnt++;
        chk_cnt++; if (mosi_q.size() !== n || trail_cnt !== 0) $display("FAIL rst_mid extra_bytes got %0d/%0d want %0d/0", mosi_q.size(), trail_cnt, n); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("rand%0d", i), 6'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 10), 8'($urandom) & 8'h7F, $urandom, 1'($urandom), -1);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8_long();
        test_timeout();
        test_keep_cs();
        test_start_ignored();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
